// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if
// Bundles the requester handshake, the ROM port and the response bus of the
// shared sprite ROM arbiter into one interface.
//
//   req_valid  per-requester read request
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready  one-hot grant
//   rom_addr   registered ROM address
//   rom_rd     registered read strobe
//   rom_q      ROM read data
//   rsp_valid  one-hot response owner
//   rsp_data   response data (rom_q passed through)
//   busy       reads in flight
//
// Modports:
//   master  the outside world: the draw units and the ROM instance
//   slave   the arbiter itself
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_addr;
  logic                      rom_rd;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rom_addr, rom_rd, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rom_addr, rom_rd, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one synchronous sprite/palette-index ROM among NUM_REQ pixel-pipeline
// requesters. At most one read is granted per vga_clk; the grant drives the
// registered ROM address one cycle later, and the requester index rides a tag
// pipeline so that the ROM word returns with a one-hot rsp_valid exactly
// 1+ROM_LAT cycles after the accept.
//
// Ports:
//   vga_clk  pixel clock, all logic on the rising edge
//   reset    synchronous, active-high
//   bus      sprite_rom_arbiter_if.slave (handshake, ROM port, responses)
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined: rotating priority pointer
//                       undefined: fixed priority, lowest index wins
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 2,
  parameter int ROM_LAT = 1
) (
  input logic            vga_clk,
  input logic            reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Worst case in flight is ROM_LAT+1 reads, so this width always suffices.
  localparam int CNT_W = $clog2(ROM_LAT + 2);

  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  grant_idx;
  logic              found;
  logic              accept;
  int                cand;
  logic [ADDR_W-1:0] sel_addr;

  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_rd_q;
  logic [IDX_W-1:0]  issue_idx;
  logic [ROM_LAT-1:0] tag_vld;
  logic [IDX_W-1:0]  tag_idx [ROM_LAT];
  logic              rsp_fire;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              busy_q;
  logic [DATA_W-1:0] rom_word;

`ifdef ARB_ROUND_ROBIN_EN
  // Priority pointer: the requester after the last winner searches first.
  logic [IDX_W-1:0] prio_ptr;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      prio_ptr <= '0;
    end else if (accept) begin
      prio_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  assign start_idx = prio_ptr;
`else
  assign start_idx = '0;
`endif

  // Search order start, start+1, ... wrapping; the first valid requester wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(start_idx) + k) % NUM_REQ;
      if (!found && bus.req_valid[IDX_W'(cand)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == grant_idx) begin
        sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign accept        = found & ~reset;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // The issue register (rom_addr/rom_rd/issue_idx) lines up with the ROM
  // input; the ROM_LAT tag stages then line up with rom_q.
  assign rsp_fire   = tag_vld[ROM_LAT-1];
  assign count_next = count + CNT_W'(accept) - CNT_W'(rsp_fire);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      issue_idx  <= '0;
      tag_vld    <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_idx[i] <= '0;
      end
      count      <= '0;
      busy_q     <= 1'b0;
    end else begin
      rom_rd_q <= accept;
      if (accept) begin
        rom_addr_q <= sel_addr;
        issue_idx  <= grant_idx;
      end
      tag_vld[0] <= rom_rd_q;
      tag_idx[0] <= issue_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      count  <= count_next;
      busy_q <= (count_next != '0);
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_rd   = rom_rd_q;
  assign bus.busy     = busy_q;

  // Responses for reads discarded by reset must not leak out in the reset
  // cycle itself, while the tag stages still hold them.
  assign bus.rsp_valid = (rsp_fire && !reset) ? (NUM_REQ'(1) << tag_idx[ROM_LAT-1]) : '0;
  assign rom_word      = bus.rom_q;
  assign bus.rsp_data  = rom_word;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
// Directed bench for sprite_rom_arbiter: one instance at ROM_LAT=1 and one at
// ROM_LAT=3, each with a model ROM returning q = addr[1:0] after ROM_LAT
// cycles. Expected grant orders follow ARB_ROUND_ROBIN_EN.
module tb_sprite_rom_arbiter;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(2)) rom_bus ();
  sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(2)) rom_bus3 ();

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(2), .ROM_LAT(1)) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (rom_bus)
  );

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(12), .DATA_W(2), .ROM_LAT(3)) dut3 (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (rom_bus3)
  );

  // Model ROMs: q = addr[1:0], ROM_LAT register stages.
  logic [1:0] q3_s1 = '0;
  logic [1:0] q3_s2 = '0;

  always @(posedge vga_clk) begin
    rom_bus.rom_q  <= rom_bus.rom_addr[1:0];
    q3_s1          <= rom_bus3.rom_addr[1:0];
    q3_s2          <= q3_s1;
    rom_bus3.rom_q <= q3_s2;
  end

  // Protocol watch: a pending (valid, not ready) request must keep its address.
  logic [2:0]  mon_pend = '0;
  logic [11:0] mon_addr [3];

  always @(negedge vga_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mon_pend[i] && rom_bus.req_valid[i] && rom_bus.req_addr[i*12 +: 12] !== mon_addr[i]) begin
        errors++;
        $display("[TB] FAIL protocol_addr_change req %0d got %h required %h", i, rom_bus.req_addr[i*12 +: 12], mon_addr[i]);
      end
      mon_pend[i] = rom_bus.req_valid[i] & ~rom_bus.req_ready[i];
      mon_addr[i] = rom_bus.req_addr[i*12 +: 12];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset;
    reset              = 1'b1;
    rom_bus.req_valid  = '0;
    rom_bus3.req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset              = 1'b1;
    rom_bus.req_valid  = 3'b111;
    rom_bus.req_addr   = '0;
    rom_bus3.req_valid = 3'b111;
    rom_bus3.req_addr  = '0;
    next_cycle();
    next_cycle();
    @(negedge vga_clk);
    checks++; if (rom_bus.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready got %b required 000", rom_bus.req_ready); end
    checks++; if (rom_bus.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_rd got %b required 0", rom_bus.rom_rd); end
    checks++; if (rom_bus.rom_addr !== 12'h000) begin errors++; $display("[TB] FAIL reset_rom_addr got %h required 000", rom_bus.rom_addr); end
    checks++; if (rom_bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b required 000", rom_bus.rsp_valid); end
    checks++; if (rom_bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b required 0", rom_bus.busy); end
    checks++; if (rom_bus3.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready3 got %b required 000", rom_bus3.req_ready); end
    rom_bus.req_valid  = '0;
    rom_bus3.req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    rom_bus.req_addr  = {12'h000, 12'h123, 12'h000};
    rom_bus.req_valid = 3'b010;
    @(negedge vga_clk);
    checks++; if (rom_bus.req_ready !== 3'b010) begin errors++; $display("[TB] FAIL single_ready got %b required 010", rom_bus.req_ready); end
    checks++; if (rom_bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_T got %b required 0", rom_bus.busy); end
    next_cycle();
    rom_bus.req_valid = 3'b000;
    @(negedge vga_clk);
    checks++; if (rom_bus.rom_addr !== 12'h123) begin errors++; $display("[TB] FAIL single_rom_addr got %h required 123", rom_bus.rom_addr); end
    checks++; if (rom_bus.rom_rd !== 1'b1) begin errors++; $display("[TB] FAIL single_rom_rd got %b required 1", rom_bus.rom_rd); end
    checks++; if (rom_bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_T1 got %b required 1", rom_bus.busy); end
    checks++; if (rom_bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL single_rsp_early got %b required 000", rom_bus.rsp_valid); end
    next_cycle();
    @(negedge vga_clk);
    checks++; if (rom_bus.rsp_valid !== 3'b010) begin errors++; $display("[TB] FAIL single_rsp_valid got %b required 010", rom_bus.rsp_valid); end
    checks++; if (rom_bus.rsp_data !== 2'd3) begin errors++; $display("[TB] FAIL single_rsp_data got %0d required 3", rom_bus.rsp_data); end
    checks++; if (rom_bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_T2 got %b required 1", rom_bus.busy); end
    checks++; if (rom_bus.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL single_rom_rd_idle got %b required 0", rom_bus.rom_rd); end
    next_cycle();
    @(negedge vga_clk);
    checks++; if (rom_bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_T3 got %b required 0", rom_bus.busy); end
    checks++; if (rom_bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL single_rsp_once got %b required 000", rom_bus.rsp_valid); end
  endtask

  task automatic test_contention;
    logic [2:0] exp_g [6];
    logic [1:0] exp_d [6];
    for (int c = 0; c < 6; c++) begin
      exp_g[c] = RR ? 3'(1 << (c % 3)) : 3'b001;
      exp_d[c] = RR ? 2'(c % 3) : 2'd0;
    end
    do_reset();
    // Requester i's address reads back as data i.
    rom_bus.req_addr  = {12'h2AA, 12'h155, 12'h0F0};
    rom_bus.req_valid = 3'b111;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      if (c == 6) rom_bus.req_valid = 3'b000;
      @(negedge vga_clk);
      if (c < 6) begin
        checks++; if (rom_bus.req_ready !== exp_g[c]) begin errors++; $display("[TB] FAIL contention_grant[%0d] got %b required %b", c, rom_bus.req_ready, exp_g[c]); end
      end
      if (c >= 2 && c < 8) begin
        checks++; if (rom_bus.rsp_valid !== exp_g[c-2]) begin errors++; $display("[TB] FAIL contention_rsp[%0d] got %b required %b", c, rom_bus.rsp_valid, exp_g[c-2]); end
        checks++; if (rom_bus.rsp_data !== exp_d[c-2]) begin errors++; $display("[TB] FAIL contention_data[%0d] got %0d required %0d", c, rom_bus.rsp_data, exp_d[c-2]); end
      end
      if (c == 8) begin
        checks++; if (rom_bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL contention_drain_busy got %b required 0", rom_bus.busy); end
      end
    end
  endtask

  task automatic test_sparse;
    logic [2:0] exp_g [4];
    for (int c = 0; c < 4; c++) begin
      exp_g[c] = (RR && (c % 2 == 1)) ? 3'b100 : 3'b001;
    end
    do_reset();
    rom_bus.req_addr  = {12'h300, 12'h200, 12'h100};
    rom_bus.req_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      @(negedge vga_clk);
      checks++; if (rom_bus.req_ready !== exp_g[c]) begin errors++; $display("[TB] FAIL sparse_grant[%0d] got %b required %b", c, rom_bus.req_ready, exp_g[c]); end
    end
    next_cycle();
    rom_bus.req_valid = 3'b000;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) next_cycle();
      if (c < 8) begin
        rom_bus.req_valid = 3'b100;
        rom_bus.req_addr  = {12'(c), 24'h000000};
      end else begin
        rom_bus.req_valid = 3'b000;
      end
      @(negedge vga_clk);
      if (c < 8) begin
        checks++; if (rom_bus.req_ready !== 3'b100) begin errors++; $display("[TB] FAIL b2b_grant[%0d] got %b required 100", c, rom_bus.req_ready); end
      end
      if (c >= 1 && c <= 8) begin
        checks++; if (rom_bus.rom_addr !== 12'(c - 1) || rom_bus.rom_rd !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rom[%0d] got addr %h rd %b required addr %h rd 1", c, rom_bus.rom_addr, rom_bus.rom_rd, 12'(c - 1)); end
      end
      if (c >= 2 && c <= 9) begin
        checks++; if (rom_bus.rsp_valid !== 3'b100) begin errors++; $display("[TB] FAIL b2b_rsp[%0d] got %b required 100", c, rom_bus.rsp_valid); end
        checks++; if (rom_bus.rsp_data !== 2'((c - 2) % 4)) begin errors++; $display("[TB] FAIL b2b_data[%0d] got %0d required %0d", c, rom_bus.rsp_data, (c - 2) % 4); end
      end
      if (c >= 1 && c <= 9) begin
        checks++; if (rom_bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy[%0d] got %b required 1", c, rom_bus.busy); end
      end
      if (c == 10) begin
        checks++; if (rom_bus.rsp_valid !== 3'b000 || rom_bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got rsp %b busy %b required rsp 000 busy 0", rom_bus.rsp_valid, rom_bus.busy); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    rom_bus.req_addr  = {12'h033, 12'h022, 12'h011};
    rom_bus.req_valid = 3'b001;
    @(negedge vga_clk);
    checks++; if (rom_bus.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL midrst_grant0 got %b required 001", rom_bus.req_ready); end
    next_cycle();
    rom_bus.req_valid = 3'b010;
    @(negedge vga_clk);
    checks++; if (rom_bus.req_ready !== 3'b010) begin errors++; $display("[TB] FAIL midrst_grant1 got %b required 010", rom_bus.req_ready); end
    next_cycle();
    reset             = 1'b1;
    rom_bus.req_valid = 3'b111;
    @(negedge vga_clk);
    checks++; if (rom_bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL midrst_rsp_in_reset got %b required 000", rom_bus.rsp_valid); end
    checks++; if (rom_bus.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL midrst_ready_in_reset got %b required 000", rom_bus.req_ready); end
    next_cycle();
    reset = 1'b0;
    @(negedge vga_clk);
    checks++; if (rom_bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b required 0", rom_bus.busy); end
    checks++; if (rom_bus.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rom_rd got %b required 0", rom_bus.rom_rd); end
    checks++; if (rom_bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL midrst_rsp_after got %b required 000", rom_bus.rsp_valid); end
    checks++; if (rom_bus.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL midrst_next_grant got %b required 001", rom_bus.req_ready); end
    next_cycle();
    rom_bus.req_valid = 3'b000;
    @(negedge vga_clk);
    checks++; if (rom_bus.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL midrst_rsp_flushed got %b required 000", rom_bus.rsp_valid); end
    checks++; if (rom_bus.rom_addr !== 12'h011 || rom_bus.rom_rd !== 1'b1) begin errors++; $display("[TB] FAIL midrst_rom got addr %h rd %b required addr 011 rd 1", rom_bus.rom_addr, rom_bus.rom_rd); end
    next_cycle();
    @(negedge vga_clk);
    checks++; if (rom_bus.rsp_valid !== 3'b001 || rom_bus.rsp_data !== 2'd1) begin errors++; $display("[TB] FAIL midrst_new_rsp got %b/%0d required 001/1", rom_bus.rsp_valid, rom_bus.rsp_data); end
  endtask

  task automatic test_rom_lat3;
    do_reset();
    rom_bus3.req_addr  = {12'h000, 12'h000, 12'h00A};
    rom_bus3.req_valid = 3'b001;
    @(negedge vga_clk);
    checks++; if (rom_bus3.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL lat3_grant got %b required 001", rom_bus3.req_ready); end
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      rom_bus3.req_valid = 3'b000;
      @(negedge vga_clk);
      checks++; if (rom_bus3.busy !== (c <= 4)) begin errors++; $display("[TB] FAIL lat3_busy[T+%0d] got %b required %b", c, rom_bus3.busy, (c <= 4)); end
      checks++; if (rom_bus3.rsp_valid !== ((c == 4) ? 3'b001 : 3'b000)) begin errors++; $display("[TB] FAIL lat3_rsp[T+%0d] got %b required %b", c, rom_bus3.rsp_valid, (c == 4) ? 3'b001 : 3'b000); end
      if (c == 4) begin
        checks++; if (rom_bus3.rsp_data !== 2'd2) begin errors++; $display("[TB] FAIL lat3_data got %0d required 2", rom_bus3.rsp_data); end
      end
    end
  endtask

  initial begin
    rom_bus.req_valid  = '0;
    rom_bus.req_addr   = '0;
    rom_bus3.req_valid = '0;
    rom_bus3.req_addr  = '0;
    $display("[TB] start, round robin = %0d", RR);
    test_reset();
    test_single();
    test_contention();
    test_sparse();
    test_back_to_back();
    test_reset_midflight();
    test_rom_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
